// File: rtl/digit_serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM state encoding and
// the elaboration-time parameter legality check.
`ifndef DIGIT_SERIAL_ADDER_PKG_SV
`define DIGIT_SERIAL_ADDER_PKG_SV

// Expands to a generate block that stops elaboration when DIGIT does not
// divide WIDTH or is out of range.
`define DSA_PARAM_CHECK(W, D) \
  if ((D) < 1 || (D) > (W) || ((W) % (D)) != 0) begin : g_illegal_params \
    $error("digit_serial_adder: WIDTH must be a positive multiple of DIGIT"); \
  end

package digit_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`endif

// File: rtl/digit_serial_adder_if.sv
// Request/result bundle of the digit-serial adder. The sub signal exists
// only when DIGIT_SERIAL_ADDER_SUB_EN is defined.
interface digit_serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cin;
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    output sub,
`endif
    output start, x, y, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    input  start, x, y, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/digit_serial_adder_digit_add.sv
// dsa_digit_add: combinational DIGIT-bit ripple adder. c_msb is the carry
// into the top bit so the caller can form the signed-overflow flag.
module dsa_digit_add #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);
  logic [DIGIT:0] c;

  // Bit-by-bit ripple through the digit
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co    = c[DIGIT];
  assign c_msb = c[DIGIT-1];
endmodule

// File: rtl/digit_serial_adder.sv
// digit_serial_adder: computes x + y + cin over WIDTH bits, DIGIT bits per
// clock, LSB digit first, behind a start/busy/done handshake.
// Optional build macro DIGIT_SERIAL_ADDER_SUB_EN adds a sub input that
// turns the operation into x + ~y + ~cin (subtract with cin as borrow-in).
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  digit_serial_adder_if.slave bus
);
  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  `DSA_PARAM_CHECK(WIDTH, DIGIT)

  state_t             state, state_nxt;
  logic               busy_c, done_c;
  logic [WIDTH-1:0]   xs, ys, acc, acc_nxt;
  logic [WIDTH-1:0]   sum_q;
  logic               carry, cout_q, ovf_q;
  logic [CNT_W-1:0]   cnt;
  logic               last;
  logic [DIGIT-1:0]   d_s;
  logic               d_co, d_cmsb;
  logic [WIDTH-1:0]   y_in;
  logic               c_in;

  dsa_digit_add #(.DIGIT(DIGIT)) u_digit (
    .a     (xs[DIGIT-1:0]),
    .b     (ys[DIGIT-1:0]),
    .ci    (carry),
    .s     (d_s),
    .co    (d_co),
    .c_msb (d_cmsb)
  );

  // New sum digit enters at the MSB end; after NDIG digits acc is aligned.
  assign acc_nxt = WIDTH'({d_s, acc} >> DIGIT);
  assign last    = (cnt == CNT_W'(NDIG - 1));

`ifdef DIGIT_SERIAL_ADDER_SUB_EN
  assign y_in = bus.sub ? ~bus.y : bus.y;
  assign c_in = bus.sub ? ~bus.cin : bus.cin;
`else
  assign y_in = bus.y;
  assign c_in = bus.cin;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: if (bus.start) state_nxt = RUN;
      RUN: begin
        busy_c = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy_c    = 1'b1;
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, digit-serial accumulation and result load on last digit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xs     <= '0;
      ys     <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          xs    <= bus.x;
          ys    <= y_in;
          carry <= c_in;
          acc   <= '0;
          cnt   <= '0;
        end
        RUN: begin
          xs    <= xs >> DIGIT;
          ys    <= ys >> DIGIT;
          acc   <= acc_nxt;
          carry <= d_co;
          cnt   <= cnt + 1'b1;
          if (last) begin
            sum_q  <= acc_nxt;
            cout_q <= d_co;
            ovf_q  <= d_co ^ d_cmsb;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_c;
  assign bus.done = done_c;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: two instances (DIGIT=2 and DIGIT=8, WIDTH=8)
// share one stimulus stream and are compared every cycle against an
// arithmetic model, plus directed literal checks.
module tb_digit_serial_adder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] x = '0, y = '0;
  logic       cin = 1'b0;
  logic       sub = 1'b0;
  logic       chk_en = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  digit_serial_adder_if #(.WIDTH(8)) bus2 ();
  digit_serial_adder_if #(.WIDTH(8)) bus8 ();

  assign bus2.start = start;
  assign bus2.x     = x;
  assign bus2.y     = y;
  assign bus2.cin   = cin;
  assign bus8.start = start;
  assign bus8.x     = x;
  assign bus8.y     = y;
  assign bus8.cin   = cin;
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
  assign bus2.sub   = sub;
  assign bus8.sub   = sub;
`endif

  digit_serial_adder #(.WIDTH(8), .DIGIT(2)) u_d2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));
  digit_serial_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic: full-precision add, then wrap and range check
  function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic c,
                                input logic s, output logic [7:0] rs, output logic rc,
                                output logic ro);
    logic [7:0] bb;
    logic       cc;
    int         full, sfull;
    bb    = s ? ~b : b;
    cc    = s ? ~c : c;
    full  = int'(a) + int'(bb) + int'(cc);
    rs    = full[7:0];
    rc    = full[8];
    sfull = int'($signed(a)) + int'($signed(bb)) + int'(cc);
    ro    = (sfull > 127) || (sfull < -128);
  endfunction

  // Model: after acceptance the block is busy for NDIG+1 cycles, done in the last
  int         ndig [2]   = '{4, 1};
  int         m_cnt [2]  = '{0, 0};
  logic [7:0] m_sum [2]  = '{8'd0, 8'd0};
  logic       m_cout [2] = '{1'b0, 1'b0};
  logic       m_ovf [2]  = '{1'b0, 1'b0};
  logic [7:0] p_sum [2]  = '{8'd0, 8'd0};
  logic       p_cout [2] = '{1'b0, 1'b0};
  logic       p_ovf [2]  = '{1'b0, 1'b0};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_cnt[k] = 0;
        m_sum[k] = '0;
        m_cout[k] = 1'b0;
        m_ovf[k] = 1'b0;
      end else if (m_cnt[k] == 0) begin
        if (start) begin
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
          model(x, y, cin, sub, p_sum[k], p_cout[k], p_ovf[k]);
`else
          model(x, y, cin, 1'b0, p_sum[k], p_cout[k], p_ovf[k]);
`endif
          m_cnt[k] = ndig[k] + 1;
        end
      end else begin
        m_cnt[k] = m_cnt[k] - 1;
        if (m_cnt[k] == 1) begin
          m_sum[k]  = p_sum[k];
          m_cout[k] = p_cout[k];
          m_ovf[k]  = p_ovf[k];
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("d2_busy", 32'(bus2.busy), 32'(m_cnt[0] != 0));
      chk("d2_done", 32'(bus2.done), 32'(m_cnt[0] == 1));
      chk("d2_sum",  32'(bus2.sum),  32'(m_sum[0]));
      chk("d2_cout", 32'(bus2.cout), 32'(m_cout[0]));
      chk("d2_ovf",  32'(bus2.ovf),  32'(m_ovf[0]));
      chk("d8_busy", 32'(bus8.busy), 32'(m_cnt[1] != 0));
      chk("d8_done", 32'(bus8.done), 32'(m_cnt[1] == 1));
      chk("d8_sum",  32'(bus8.sum),  32'(m_sum[1]));
      chk("d8_cout", 32'(bus8.cout), 32'(m_cout[1]));
      chk("d8_ovf",  32'(bus8.ovf),  32'(m_ovf[1]));
    end
  end

  // One operation from idle; returns at the negedge where DIGIT=2 done is high
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] held, output int l2, output int l8);
    @(negedge clk);
    x = a; y = b; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("held_sum", 32'(bus2.sum), 32'(held));
    l2 = -1;
    l8 = -1;
    for (int n = 1; n <= 20 && l2 < 0; n++) begin
      @(negedge clk);
      if (l8 < 0 && bus8.done === 1'b1) l8 = n;
      if (bus2.done === 1'b1) l2 = n;
    end
    if (l2 < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=none required=done within 20 cycles");
    end
  endtask

  initial begin
    int l2, l8, lat;
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(bus2.busy), 32'd0);
    chk("rst_sum", 32'(bus2.sum), 32'd0);
    rst_n = 1'b1;

    // Max operands: latency and result
    run_op(8'd255, 8'd255, 1'b0, 8'd0, l2, l8);
    chk("lat_d2", 32'(l2), 32'd4);
    chk("ff_sum", 32'(bus2.sum), 32'd254);
    chk("ff_cout", 32'(bus2.cout), 32'd1);
    chk("ff_ovf", 32'(bus2.ovf), 32'd0);
    @(negedge clk);
    chk("busy_drop", 32'(bus2.busy), 32'd0);

    run_op(8'd123, 8'd246, 1'b1, 8'd254, l2, l8);
    chk("a_sum", 32'(bus2.sum), 32'd114);
    chk("a_cout", 32'(bus2.cout), 32'd1);
    chk("a_ovf", 32'(bus2.ovf), 32'd0);
    run_op(8'd100, 8'd50, 1'b0, 8'd114, l2, l8);
    chk("b_sum", 32'(bus2.sum), 32'd150);
    chk("b_cout", 32'(bus2.cout), 32'd0);
    chk("b_ovf", 32'(bus2.ovf), 32'd1);
    repeat (2) @(negedge clk);

    // start held high; operands change mid-run
    x = 8'd20; y = 8'd30; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    x = 8'd7; y = 8'd11;
    lat = -1;
    for (int n = 1; n <= 20 && lat < 0; n++) begin
      @(negedge clk);
      if (bus2.done === 1'b1) lat = n;
    end
    chk("hold_lat", 32'(lat), 32'd4);
    chk("hold_sum1", 32'(bus2.sum), 32'd50);
    lat = -1;
    for (int n = 1; n <= 20 && lat < 0; n++) begin
      @(negedge clk);
      if (bus2.done === 1'b1) lat = n;
    end
    chk("hold_ii", 32'(lat), 32'd6);
    chk("hold_sum2", 32'(bus2.sum), 32'd18);
    start = 1'b0;
    repeat (3) @(negedge clk);

    // Reset during the second RUN cycle aborts the operation
    x = 8'd1; y = 8'd2; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", 32'(bus2.busy), 32'd0);
    chk("abort_done", 32'(bus2.done), 32'd0);
    chk("abort_sum", 32'(bus2.sum), 32'd0);
    chk("abort_cout", 32'(bus2.cout), 32'd0);
    chk("abort_ovf", 32'(bus2.ovf), 32'd0);
    run_op(8'd66, 8'd99, 1'b0, 8'd0, l2, l8);
    chk("c_sum", 32'(bus2.sum), 32'd165);
    chk("c_cout", 32'(bus2.cout), 32'd0);
    chk("c_ovf", 32'(bus2.ovf), 32'd1);

    // Single-digit instance
    run_op(8'd88, 8'd22, 1'b1, 8'd165, l2, l8);
    chk("lat_d8", 32'(l8), 32'd1);
    chk("d8_lit_sum", 32'(bus8.sum), 32'd111);
    chk("d8_lit_cout", 32'(bus8.cout), 32'd0);
    chk("d8_lit_ovf", 32'(bus8.ovf), 32'd0);

`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    sub = 1'b1;
    run_op(8'd7, 8'd11, 1'b0, 8'd111, l2, l8);
    chk("s1_sum", 32'(bus2.sum), 32'd252);
    chk("s1_cout", 32'(bus2.cout), 32'd0);
    chk("s1_ovf", 32'(bus2.ovf), 32'd0);
    run_op(8'd168, 8'd66, 1'b1, 8'd252, l2, l8);
    chk("s2_sum", 32'(bus2.sum), 32'd101);
    chk("s2_cout", 32'(bus2.cout), 32'd1);
    chk("s2_ovf", 32'(bus2.ovf), 32'd1);
    sub = 1'b0;
`endif

    // Random traffic: start pulses while busy, operand churn, rare resets
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      x     = 8'($urandom);
      y     = 8'($urandom);
      cin   = 1'($urandom);
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
      sub   = 1'($urandom);
`endif
      rst_n = ($urandom_range(0, 79) != 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    repeat (8) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
